// File: rtl/maze_game_core.sv
// Room-grid maze game core: one-hot N/S/E/W moves, pits with lives and respawn, a move budget and a goal room.
// Optional build macro MAZE_GAME_WRAP_EN makes the grid edges wrap toroidally; by default, moves off the grid are blocked.
//
// state | meaning
// ------+---------------------------------------------
// PLAY  | accepting moves
// WIN   | goal reached; terminal until reset, win=1
// DEAD  | lives or move budget exhausted; terminal, d=1
module maze_game_core #(
    parameter int GRID_W    = 4,
    parameter int GRID_H    = 4,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int GOAL_X    = 3,
    parameter int GOAL_Y    = 3,
    parameter logic [GRID_W*GRID_H-1:0] PIT_MAP = 16'h0420,
    parameter int LIVES     = 3,
    parameter int MAX_MOVES = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           n,
    input  logic                           s,
    input  logic                           e,
    input  logic                           w,
    output logic [$clog2(GRID_W)-1:0]      pos_x,
    output logic [$clog2(GRID_H)-1:0]      pos_y,
    output logic [$clog2(LIVES+1)-1:0]     lives,
    output logic [$clog2(MAX_MOVES+1)-1:0] move_cnt,
    output logic                           hit,
    output logic                           d,
    output logic                           win
);

    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int LW    = $clog2(LIVES + 1);
    localparam int MW    = $clog2(MAX_MOVES + 1);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int CW    = $clog2(CELLS);

`ifdef MAZE_GAME_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [XW-1:0] START_XV = XW'(START_X);
    localparam logic [YW-1:0] START_YV = YW'(START_Y);
    localparam logic [XW-1:0] GOAL_XV  = XW'(GOAL_X);
    localparam logic [YW-1:0] GOAL_YV  = YW'(GOAL_Y);
    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
    localparam logic [LW-1:0] LIVES_V  = LW'(LIVES);
    localparam logic [MW-1:0] BUDGET   = MW'(MAX_MOVES);

    localparam logic [CELLS-1:0] PIT_BITS   = PIT_MAP;
    localparam bit GOAL_IS_PIT  = |(PIT_BITS & (CELLS'(1) << (GOAL_Y * GRID_W + GOAL_X)));
    localparam bit START_IS_PIT = |(PIT_BITS & (CELLS'(1) << (START_Y * GRID_W + START_X)));

    // Illegal maps are rejected at elaboration rather than producing an unwinnable or instantly-won game.
    if (GOAL_IS_PIT) begin : g_chk_goal_pit
        $error("maze_game_core: goal cell is marked as a pit");
    end
    if (START_IS_PIT) begin : g_chk_start_pit
        $error("maze_game_core: start cell is marked as a pit");
    end
    if (START_X == GOAL_X && START_Y == GOAL_Y) begin : g_chk_start_goal
        $error("maze_game_core: start cell equals goal cell");
    end

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            move_ok;
    logic [XW-1:0]   tgt_x;
    logic [YW-1:0]   tgt_y;
    logic [CW-1:0]   cell_idx;
    logic            tgt_goal;
    logic            tgt_pit;
    logic [XW-1:0]   x_nxt;
    logic [YW-1:0]   y_nxt;
    logic [LW-1:0]   lives_nxt;
    logic [MW-1:0]   mc_nxt;
    logic            hit_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Target cell of the requested move; blocked edges keep the current cell.
    always_comb begin
        move_ok = 1'b0;
        tgt_x   = pos_x;
        tgt_y   = pos_y;
        if (state_q == PLAY) begin
            case ({n, s, e, w})
                4'b1000: begin
                    move_ok = 1'b1;
                    if (pos_y == '0) tgt_y = WRAP ? Y_MAX : pos_y;
                    else             tgt_y = pos_y - YW'(1);
                end
                4'b0100: begin
                    move_ok = 1'b1;
                    if (pos_y == Y_MAX) tgt_y = WRAP ? '0 : pos_y;
                    else                tgt_y = pos_y + YW'(1);
                end
                4'b0010: begin
                    move_ok = 1'b1;
                    if (pos_x == X_MAX) tgt_x = WRAP ? '0 : pos_x;
                    else                tgt_x = pos_x + XW'(1);
                end
                4'b0001: begin
                    move_ok = 1'b1;
                    if (pos_x == '0) tgt_x = WRAP ? X_MAX : pos_x;
                    else             tgt_x = pos_x - XW'(1);
                end
                default: move_ok = 1'b0;
            endcase
        end
    end

    assign cell_idx = CW'(int'(tgt_y) * GRID_W + int'(tgt_x));
    assign tgt_goal = (tgt_x == GOAL_XV) && (tgt_y == GOAL_YV);
    assign tgt_pit  = PIT_BITS[cell_idx];

    // Goal outranks pit; the budget check runs last so a win on the final move still wins.
    always_comb begin
        state_nxt = state_q;
        x_nxt     = pos_x;
        y_nxt     = pos_y;
        lives_nxt = lives;
        mc_nxt    = move_cnt;
        hit_nxt   = 1'b0;
        if (move_ok) begin
            mc_nxt = move_cnt + MW'(1);
            if (tgt_goal) begin
                x_nxt     = tgt_x;
                y_nxt     = tgt_y;
                state_nxt = WIN;
            end else if (tgt_pit) begin
                hit_nxt   = 1'b1;
                lives_nxt = lives - LW'(1);
                x_nxt     = START_XV;
                y_nxt     = START_YV;
                if (lives == LW'(1)) state_nxt = DEAD;
            end else begin
                x_nxt = tgt_x;
                y_nxt = tgt_y;
            end
            if (mc_nxt == BUDGET && state_nxt != WIN) state_nxt = DEAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x    <= START_XV;
            pos_y    <= START_YV;
            lives    <= LIVES_V;
            move_cnt <= '0;
            hit      <= 1'b0;
            d        <= 1'b0;
            win      <= 1'b0;
        end else begin
            pos_x    <= x_nxt;
            pos_y    <= y_nxt;
            lives    <= lives_nxt;
            move_cnt <= mc_nxt;
            hit      <= hit_nxt;
            d        <= (state_nxt == DEAD);
            win      <= (state_nxt == WIN);
        end
    end

endmodule

// File: doc/maze_game_core.md
Name: maze_game_core

Overview:
- Parametrised successor to the single-maze N/S/E/W game FSM: player moves on a GRID_W x GRID_H room grid from one-hot direction inputs.
- Adds pit hazards with a life counter and respawn, a move budget, a goal room, and registered status outputs.
- Sits behind the GameIf interface. The directed bench drives n/s/e/w and stops on d or win.

Parameters:
- GRID_W, 4, rooms per row (>=2)
- GRID_H, 4, rooms per column (>=2)
- START_X, 0, respawn/reset column
- START_Y, 0, respawn/reset row
- GOAL_X, 3, goal column
- GOAL_Y, 3, goal row
- PIT_MAP, 16'h0420, GRID_W*GRID_H-bit map; bit index y*GRID_W+x set = pit. Bits 5 (1,1) and 10 (2,2) by default.
- LIVES, 3, lives at reset (>=1)
- MAX_MOVES, 32, move budget (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- n  in  1  move north (y-1)
- s  in  1  move south (y+1)
- e  in  1  move east (x+1)
- w  in  1  move west (x-1)
- pos_x  out  XW=$clog2(GRID_W)  current column
- pos_y  out  YW=$clog2(GRID_H)  current row
- lives  out  $clog2(LIVES+1)  remaining lives
- move_cnt  out  $clog2(MAX_MOVES+1)  moves taken
- hit  out  1  one-cycle pulse: pit entered this edge
- d  out  1  dead, sticky
- win  out  1  goal reached, sticky

Behaviour:
- Reset (async assert, sync release):
  - state=PLAY, pos=(START_X,START_Y), lives=LIVES, move_cnt=0.
  - hit=0, d=0, win=0.
- States:
  - PLAY: moves accepted.
  - WIN: terminal; win=1.
  - DEAD: terminal; d=1.
  - WIN and DEAD hold until reset; no further moves, counters frozen.
- Valid move: exactly one of n/s/e/w high at a rising edge while in PLAY.
  - Zero or multiple directions high: no-op. Position, move_cnt and state unchanged.
- Each valid move increments move_cnt by 1, including moves blocked by a wall.
- Edge handling without the optional feature: a move off the grid leaves the position unchanged.
- Landing-cell evaluation, in priority order, all resolved at the same edge as the move:
  1. Goal cell: pos updated, state->WIN. win=1 from that edge, with no extra latency.
  2. Pit cell: hit=1 for one cycle; lives-=1; pos forced to (START_X,START_Y) instead of the pit. If lives reaches 0, state->DEAD with d=1.
  3. Otherwise pos updated.
- Move budget: if the new move_cnt == MAX_MOVES and the state is not WIN after the above, state->DEAD.
  - A win on the final budgeted move therefore wins.
  - A pit hit on the final move sets hit=1 and d=1 at the same edge.
- Goal and start cells must not be pits; the start must not be the goal. Elaboration-time $error if violated.
- All outputs are registered; no combinational input-to-output path.
- Reset asserted mid-game: immediate return to reset values regardless of state.

Optional Feature:
- Macro MAZE_GAME_WRAP_EN.
- Defined: edges wrap toroidally.
  - N at y=0 -> y=GRID_H-1; S at y=GRID_H-1 -> 0.
  - W at x=0 -> x=GRID_W-1; E at x=GRID_W-1 -> 0.
  - The wrapped cell then goes through normal goal/pit evaluation.
- Undefined: off-grid moves are blocked as above; the move still counts.

Test Plan:
- Defaults, E,E,E,S,S,S on consecutive edges -> pos reaches (3,3) at edge 6, win=1, move_cnt=6, lives=3, d=0; further inputs change nothing.
- S then E -> (0,1), then pit (1,1): at edge 2 hit=1 for one cycle, pos=(0,0), lives=2, move_cnt=2.
- Three pit entries (S,E repeated 3x) -> after the 6th move lives=0, d=1, hit=1 on that edge, win=0.
- N at (0,0) with wrap off -> pos stays (0,0), move_cnt=1. With MAZE_GAME_WRAP_EN, N -> (0,3) and W -> (3,0).
- n=e=1 simultaneously, then all low -> no move, move_cnt=0. 32 valid N moves (wrap off) -> d=1 at edge 32.
- Assert reset_n=0 asynchronously mid-move after 2 moves -> outputs clear to reset values before the next edge. After release, the game restarts from (0,0) with lives=3.
